mem_port_arbiter: RTL and testbench

//  Shares one single-ported instruction/data memory between the fetch stage (read-only)
//  and the memory-access stage (read/write). One transaction is in flight at a time.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, the arbiter and the single-ported memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_flush;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, if_flush, d_req, d_we, d_be, d_addr, d_wdata,
               mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    // Requester/memory side
    modport master (
        output if_req, if_addr, if_flush, d_req, d_we, d_be, d_addr, d_wdata,
               mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-ported memory, data-priority with starvation override.
// Latency: grant and memory command same cycle; requester rvalid one cycle after mem_rvalid.
// Backpressure: one op outstanding; requests hold until gnt. MEM_ARB_STATS_EN adds grant counters.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]          stat_if_grants,
    output logic [31:0]          stat_d_grants,
    output logic [31:0]          stat_forced
`endif
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t             state_q, state_d;
    logic               owner_fetch_q, owner_fetch_d;
    logic               drop_q, drop_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic [DATA_W-1:0]  rdata_q;
    logic               if_rvalid_q, if_rvalid_d;
    logic               d_rvalid_q, d_rvalid_d;
    logic               cap_rdata;
    logic               fetch_ok, forced, grant_if, grant_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            owner_fetch_q <= 1'b0;
            drop_q        <= 1'b0;
            starve_q      <= '0;
            rdata_q       <= '0;
            if_rvalid_q   <= 1'b0;
            d_rvalid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_fetch_q <= owner_fetch_d;
            drop_q        <= drop_d;
            starve_q      <= starve_d;
            if_rvalid_q   <= if_rvalid_d;
            d_rvalid_q    <= d_rvalid_d;
            if (cap_rdata) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_fetch_d = owner_fetch_q;
        drop_d        = drop_q;
        starve_d      = starve_q;
        if_rvalid_d   = 1'b0;
        d_rvalid_d    = 1'b0;
        cap_rdata     = 1'b0;
        fetch_ok      = 1'b0;
        forced        = 1'b0;
        grant_if      = 1'b0;
        grant_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A fetch being flushed this cycle is never granted, even when forced.
                fetch_ok = bus.if_req && !bus.if_flush;
                forced   = fetch_ok && (starve_q == LIMIT);
                grant_if = fetch_ok && (forced || !bus.d_req);
                grant_d  = bus.d_req && !grant_if;
                if (grant_if) begin
                    state_d       = ST_WAIT;
                    owner_fetch_d = 1'b1;
                    drop_d        = 1'b0;
                    starve_d      = '0;
                end else if (grant_d) begin
                    state_d       = ST_WAIT;
                    owner_fetch_d = 1'b0;
                    drop_d        = 1'b0;
                    if (!bus.if_req) begin
                        starve_d = '0;
                    end else if (starve_q != LIMIT) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (!bus.if_req) begin
                    starve_d = '0;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d   = ST_IDLE;
                    cap_rdata = 1'b1;
                    drop_d    = 1'b0;
                    if (owner_fetch_q) begin
                        if_rvalid_d = !(drop_q || bus.if_flush);
                    end else begin
                        d_rvalid_d = 1'b1;
                    end
                end else if (owner_fetch_q && bus.if_flush) begin
                    drop_d = 1'b1;
                end
            end
        endcase
    end

    assign bus.if_gnt    = grant_if;
    assign bus.d_gnt     = grant_d;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = rdata_q;
    assign bus.d_rdata   = rdata_q;

    assign bus.mem_req   = grant_if || grant_d;
    assign bus.mem_we    = grant_d && bus.d_we;
    assign bus.mem_be    = grant_d ? bus.d_be : (grant_if ? {BE_W{1'b1}} : {BE_W{1'b0}});
    assign bus.mem_addr  = grant_d ? bus.d_addr : (grant_if ? bus.if_addr : {ADDR_W{1'b0}});
    assign bus.mem_wdata = grant_d ? bus.d_wdata : {DATA_W{1'b0}};

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_if_grants <= '0;
            stat_d_grants  <= '0;
            stat_forced    <= '0;
        end else begin
            if (grant_if) stat_if_grants <= stat_if_grants + 32'd1;
            if (grant_d)  stat_d_grants  <= stat_d_grants + 32'd1;
            if (grant_if && forced) stat_forced <= stat_forced + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] st_if, st_d, st_f;
`endif

    mem_port_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_grants (st_if),
        .stat_d_grants  (st_d),
        .stat_forced    (st_f)
`endif
    );

    int checks = 0;
    int errors = 0;

    // staged requester inputs, applied just after the next rising edge
    logic        s_rst, s_if_req, s_if_flush, s_d_req, s_d_we;
    logic [31:0] s_if_addr, s_d_addr, s_d_wdata;
    logic [3:0]  s_d_be;

    // memory environment: one command in flight, fixed or random latency
    logic [31:0] mem [64];
    bit          mp;
    int          mcnt;
    int          mem_lat;
    logic [31:0] mresp;

    // transaction-level reference state
    bit          m_busy, m_owner_f, m_drop, m_rv_if, m_rv_d;
    int          m_run;
    logic [31:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit e_ifg, e_dg, fok;
        e_ifg = 0;
        e_dg  = 0;
        if (!s_rst) begin
            m_busy = 0; m_run = 0; m_rv_if = 0; m_rv_d = 0; m_drop = 0; m_rdata = '0;
        end else if (!m_busy) begin
            fok   = s_if_req && !s_if_flush;
            e_ifg = fok && (m_run == LIM || !s_d_req);
            e_dg  = s_d_req && !e_ifg;
        end
        chk("if_gnt", bus.if_gnt, e_ifg);
        chk("d_gnt", bus.d_gnt, e_dg);
        chk("mem_req", bus.mem_req, e_ifg | e_dg);
        if (e_ifg) begin
            chk("mem_we_f", bus.mem_we, 0);
            chk("mem_be_f", bus.mem_be, 4'hF);
            chk("mem_addr_f", bus.mem_addr, s_if_addr);
        end
        if (e_dg) begin
            chk("mem_we_d", bus.mem_we, s_d_we);
            chk("mem_be_d", bus.mem_be, s_d_be);
            chk("mem_addr_d", bus.mem_addr, s_d_addr);
            chk("mem_wdata_d", bus.mem_wdata, s_d_wdata);
        end
        chk("if_rvalid", bus.if_rvalid, m_rv_if);
        chk("d_rvalid", bus.d_rvalid, m_rv_d);
        if (m_rv_if) chk("if_rdata", bus.if_rdata, m_rdata);
        if (m_rv_d)  chk("d_rdata", bus.d_rdata, m_rdata);
        if (!s_rst) begin
            chk("rst_if_rdata", bus.if_rdata, 0);
            chk("rst_d_rdata", bus.d_rdata, 0);
            return;
        end
        // advance to the next cycle
        m_rv_if = 0;
        m_rv_d  = 0;
        if (!m_busy) begin
            if (e_ifg) begin
                m_run = 0; m_busy = 1; m_owner_f = 1; m_drop = 0;
            end else if (e_dg) begin
                m_run  = s_if_req ? ((m_run < LIM) ? m_run + 1 : LIM) : 0;
                m_busy = 1; m_owner_f = 0; m_drop = 0;
            end else if (!s_if_req) begin
                m_run = 0;
            end
        end else if (bus.mem_rvalid) begin
            m_busy  = 0;
            m_rdata = bus.mem_rdata;
            if (m_owner_f) m_rv_if = !(m_drop || s_if_flush);
            else           m_rv_d  = 1;
            m_drop = 0;
        end else if (m_owner_f && s_if_flush) begin
            m_drop = 1;
        end
    endtask

    task automatic tick();
        int idx;
        @(posedge clk);
        #1;
        rst          = s_rst;
        bus.if_req   = s_if_req;
        bus.if_addr  = s_if_addr;
        bus.if_flush = s_if_flush;
        bus.d_req    = s_d_req;
        bus.d_we     = s_d_we;
        bus.d_be     = s_d_be;
        bus.d_addr   = s_d_addr;
        bus.d_wdata  = s_d_wdata;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
        if (mp) begin
            mcnt--;
            if (mcnt == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mresp;
                mp = 0;
            end
        end
        @(negedge clk);
        model_check();
        if (bus.mem_req === 1'b1) begin
            mp   = 1;
            mcnt = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 4));
            idx  = int'(bus.mem_addr[7:2]);
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) mem[idx][b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
                mresp = $urandom;
            end else begin
                mresp = mem[idx];
            end
        end
    endtask

    task automatic idle_inputs();
        s_if_req = 0; s_if_flush = 0; s_d_req = 0; s_d_we = 0; s_d_be = '0;
        s_if_addr = '0; s_d_addr = '0; s_d_wdata = '0;
    endtask

    int          ngr;
    bit          gseq [10];
    logic [31:0] exp_w;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] f0, i0, d0;
`endif

    initial begin
        bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mp = 0; mcnt = 0; mresp = '0; mem_lat = 2;
        m_busy = 0; m_owner_f = 0; m_drop = 0; m_rv_if = 0; m_rv_d = 0; m_run = 0; m_rdata = '0;
        idle_inputs();
        s_rst = 0;
        tick(); tick();
        chk("reset_if_gnt", bus.if_gnt, 0);
        chk("reset_mem_req", bus.mem_req, 0);
        chk("reset_if_rvalid", bus.if_rvalid, 0);
        chk("reset_d_rvalid", bus.d_rvalid, 0);
        s_rst = 1;
        tick();

        // single fetch, memory latency 2
        mem[16] = 32'h0000_0013;
        s_if_req = 1; s_if_addr = 32'h40;
        tick();
        chk("t2_if_gnt_c0", bus.if_gnt, 1);
        chk("t2_mem_addr_c0", bus.mem_addr, 32'h40);
        s_if_req = 0;
        tick(); tick(); tick();
        chk("t2_if_rvalid_c3", bus.if_rvalid, 1);
        chk("t2_if_rdata_c3", bus.if_rdata, 32'h13);

        // partial write then read-back
        mem_lat = 1;
        mem[8] = 32'h1122_3344;
        s_d_req = 1; s_d_we = 1; s_d_be = 4'b0011; s_d_addr = 32'h20; s_d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("t6_d_gnt", bus.d_gnt, 1);
        chk("t6_mem_we", bus.mem_we, 1);
        chk("t6_mem_be", bus.mem_be, 4'b0011);
        idle_inputs();
        tick();
        chk("t6_d_rvalid_early", bus.d_rvalid, 0);
        tick();
        chk("t6_d_rvalid", bus.d_rvalid, 1);
        s_d_req = 1; s_d_addr = 32'h20;
        tick();
        idle_inputs();
        tick(); tick();
        chk("t6_readback_vld", bus.d_rvalid, 1);
        chk("t6_readback_dat", bus.d_rdata, 32'h1122_BEEF);

        // simultaneous fetch and data read
        mem[0] = 32'hA0A0_A0A0; mem[32] = 32'hB0B0_B0B0;
        s_if_req = 1; s_if_addr = 32'h80; s_d_req = 1; s_d_addr = 32'h100;
        tick();
        chk("t3_d_first", bus.d_gnt, 1);
        chk("t3_if_wait", bus.if_gnt, 0);
        s_d_req = 0;
        tick();
        chk("t3_no_gnt_wait", bus.if_gnt, 0);
        tick();
        chk("t3_d_rvalid", bus.d_rvalid, 1);
        chk("t3_d_rdata", bus.d_rdata, 32'hA0A0_A0A0);
        chk("t3_if_gnt", bus.if_gnt, 1);
        s_if_req = 0;
        tick(); tick();
        chk("t3_if_rvalid", bus.if_rvalid, 1);
        chk("t3_if_rdata", bus.if_rdata, 32'hB0B0_B0B0);
        chk("t3_d_quiet", bus.d_rvalid, 0);
        tick();

        // starvation: both held high
`ifdef MEM_ARB_STATS_EN
        f0 = st_f; i0 = st_if; d0 = st_d;
`endif
        s_d_req = 1; s_d_addr = 32'h0; s_if_req = 1; s_if_addr = 32'h4;
        ngr = 0;
        for (int c = 0; c < 60 && ngr < 10; c++) begin
            tick();
            if (bus.d_gnt === 1'b1) begin gseq[ngr] = 0; ngr++; end
            else if (bus.if_gnt === 1'b1) begin gseq[ngr] = 1; ngr++; end
        end
        chk("t4_grant_count", ngr, 10);
        for (int g = 0; g < 10; g++)
            chk($sformatf("t4_grant_%0d", g), {31'd0, gseq[g]}, (g == 4 || g == 9) ? 1 : 0);
`ifdef MEM_ARB_STATS_EN
        chk("t4_stat_forced", st_f - f0, 2);
        chk("t4_stat_if", st_if - i0, 2);
        chk("t4_stat_d", st_d - d0, 8);
`endif
        idle_inputs();
        tick(); tick(); tick();

        // flush of an in-flight fetch, latency 3
        mem_lat = 3;
        s_if_req = 1; s_if_addr = 32'h40;
        tick();
        chk("t5_if_gnt", bus.if_gnt, 1);
        s_if_req = 0; s_if_flush = 1;
        tick();
        s_if_flush = 0; s_d_req = 1; s_d_addr = 32'h8;
        tick();
        chk("t5_d_blocked_c2", bus.d_gnt, 0);
        tick();
        chk("t5_d_blocked_c3", bus.d_gnt, 0);
        tick();
        chk("t5_if_rvalid_dropped", bus.if_rvalid, 0);
        chk("t5_d_gnt_after", bus.d_gnt, 1);
        idle_inputs();
        tick(); tick(); tick(); tick();

        // reset in the middle of a fetch
        s_if_req = 1; s_if_addr = 32'h40;
        tick();
        s_if_req = 0;
        tick();
        s_rst = 0;
        tick();
        chk("t1_if_rvalid", bus.if_rvalid, 0);
        chk("t1_d_rvalid", bus.d_rvalid, 0);
        chk("t1_mem_req", bus.mem_req, 0);
        chk("t1_if_gnt", bus.if_gnt, 0);
        chk("t1_d_gnt", bus.d_gnt, 0);
        s_rst = 1;
        tick();
        tick();
        chk("t1_late_resp_ignored", {30'd0, bus.if_rvalid, bus.d_rvalid}, 0);
        s_d_req = 1; s_d_addr = 32'hC;
        tick();
        chk("t1_idle_after", bus.d_gnt, 1);
        idle_inputs();
        for (int c = 0; c < 6; c++) tick();

        // randomized traffic
        mem_lat = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!(s_if_req && bus.if_gnt !== 1'b1)) begin
                s_if_req  = ($urandom % 3 == 0);
                s_if_addr = $urandom & 32'hFC;
            end
            s_if_flush = ($urandom % 12 == 0);
            if (!(s_d_req && bus.d_gnt !== 1'b1)) begin
                s_d_req   = ($urandom % 2 == 0);
                s_d_we    = $urandom;
                s_d_be    = $urandom;
                s_d_addr  = $urandom & 32'hFC;
                s_d_wdata = $urandom;
            end
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 8; c++) tick();

        exp_w = mem[8];
        s_d_req = 1; s_d_we = 0; s_d_addr = 32'h20; mem_lat = 1;
        tick();
        idle_inputs();
        tick(); tick();
        chk("end_readback", bus.d_rdata, exp_w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
